// File: rtl/acc_mem_arbiter.sv
// Round-robin arbiter that serialises level-held accelerator read/write requests
// onto a single data-memory port and returns a one-cycle completion pulse to the owner.
module acc_mem_arbiter #(
   parameter int NUM_ACC      = 2,
   parameter int ADDR_SIZE    = 16,
   parameter int RD_DATA_SIZE = 512,
   parameter int WR_DATA_SIZE = 32,
   parameter int RD_LATENCY   = 1
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic [NUM_ACC-1:0]                acc_rd_en,
   input  logic [NUM_ACC*ADDR_SIZE-1:0]      acc_rd_addr,
   input  logic [NUM_ACC-1:0]                acc_wr_en,
   input  logic [NUM_ACC*ADDR_SIZE-1:0]      acc_wr_addr,
   input  logic [NUM_ACC*WR_DATA_SIZE-1:0]   acc_wr_data,
   output logic [RD_DATA_SIZE-1:0]           acc_rd_data,
   output logic [NUM_ACC-1:0]                acc_rd_data_valid,
   output logic [NUM_ACC-1:0]                acc_wr_done,
   output logic                              mem_rd_en,
   output logic                              mem_wr_en,
   output logic [ADDR_SIZE-1:0]              mem_addr,
   output logic [WR_DATA_SIZE-1:0]           mem_wr_data,
   input  logic [RD_DATA_SIZE-1:0]           mem_rd_data,
   output logic                              busy
);

   localparam int PW = (NUM_ACC > 1) ? $clog2(NUM_ACC) : 1;
   localparam int CW = $clog2(RD_LATENCY + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(RD_LATENCY - 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(NUM_ACC - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WR_DONE,
      S_RD,
      S_RD_WAIT,
      S_RD_RESP
   } state_t;

   state_t                    r_state;
   logic [PW-1:0]             r_rr_ptr;
   logic [PW-1:0]             r_gnt;
   logic                      r_op;
   logic [ADDR_SIZE-1:0]      r_addr;
   logic [WR_DATA_SIZE-1:0]   r_wdata;
   logic [CW-1:0]             r_cnt;
   logic [RD_DATA_SIZE-1:0]   r_rd_data;
   logic [NUM_ACC-1:0]        r_rd_valid;
   logic [NUM_ACC-1:0]        r_wr_done;
   logic                      r_mem_rd_en;
   logic                      r_mem_wr_en;
   logic                      r_busy;

   logic [NUM_ACC-1:0]        w_req;
   logic                      w_any;
   logic [PW-1:0]             w_win;
   logic                      w_win_wr;
   logic [ADDR_SIZE-1:0]      w_win_addr;
   logic [WR_DATA_SIZE-1:0]   w_win_data;
   logic [PW-1:0]             w_next;
   logic [NUM_ACC-1:0]        w_gnt_oh;
   int                        w_idx;

   assign w_req    = acc_wr_en | acc_rd_en;
   assign w_next   = (w_win == PTR_LAST) ? '0 : w_win + 1'b1;
   assign w_gnt_oh = NUM_ACC'(1) << r_gnt;

   // Scan from rr_ptr upward with wrap; the first requester found wins, and a
   // pending write beats a pending read from the same requester.
   always_comb begin
      // NOTE: every combinational output gets a default before the loop so no latch is inferred.
      w_any      = 1'b0;
      w_win      = '0;
      w_win_wr   = 1'b0;
      w_win_addr = '0;
      w_win_data = '0;
      w_idx      = 0;
      for (int k = 0; k < NUM_ACC; k++) begin
         w_idx = int'(r_rr_ptr) + k;
         if (w_idx >= NUM_ACC) w_idx = w_idx - NUM_ACC;
         if (!w_any && w_req[w_idx]) begin
            w_any      = 1'b1;
            w_win      = PW'(w_idx);
            w_win_wr   = acc_wr_en[w_idx];
            w_win_addr = acc_wr_en[w_idx] ? acc_wr_addr[w_idx*ADDR_SIZE +: ADDR_SIZE]
                                          : acc_rd_addr[w_idx*ADDR_SIZE +: ADDR_SIZE];
            w_win_data = acc_wr_data[w_idx*WR_DATA_SIZE +: WR_DATA_SIZE];
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_rr_ptr    <= '0;
         r_gnt       <= '0;
         r_op        <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_cnt       <= '0;
         r_rd_data   <= '0;
         r_rd_valid  <= '0;
         r_wr_done   <= '0;
         r_mem_rd_en <= 1'b0;
         r_mem_wr_en <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_any) begin
                  r_gnt    <= w_win;
                  r_rr_ptr <= w_next;
                  r_op     <= w_win_wr;
                  r_addr   <= w_win_addr;
                  r_wdata  <= w_win_data;
                  r_busy   <= 1'b1;
                  if (w_win_wr) begin
                     r_mem_wr_en <= 1'b1;
                     r_state     <= S_WR;
                  end else begin
                     r_mem_rd_en <= 1'b1;
                     r_state     <= S_RD;
                  end
               end
            end
            S_WR: begin
               r_mem_wr_en <= 1'b0;
               r_wr_done   <= w_gnt_oh;
               r_state     <= S_WR_DONE;
            end
            S_WR_DONE: begin
               r_wr_done <= '0;
               r_busy    <= 1'b0;
               r_state   <= S_IDLE;
            end
            S_RD: begin
               r_mem_rd_en <= 1'b0;
               r_cnt       <= '0;
               r_state     <= S_RD_WAIT;
            end
            S_RD_WAIT: begin
               r_cnt <= r_cnt + 1'b1;
               // Memory data is valid in the RD_LATENCY-th cycle after the strobe.
               if (r_cnt == CNT_LAST) begin
                  r_rd_data  <= mem_rd_data;
                  r_rd_valid <= w_gnt_oh;
                  r_state    <= S_RD_RESP;
               end
            end
            S_RD_RESP: begin
               r_rd_valid <= '0;
               r_busy     <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Address and write data are forced to zero whenever no strobe is active.
   assign mem_rd_en         = r_mem_rd_en;
   assign mem_wr_en         = r_mem_wr_en;
   assign mem_addr          = (r_mem_wr_en | r_mem_rd_en) ? r_addr : '0;
   assign mem_wr_data       = (r_mem_wr_en & r_op) ? r_wdata : '0;
   assign acc_rd_data       = r_rd_data;
   assign acc_rd_data_valid = r_rd_valid;
   assign acc_wr_done       = r_wr_done;
   assign busy              = r_busy;

endmodule

// File: tb/tb_acc_mem_arbiter.sv
// Scoreboard bench for acc_mem_arbiter: directed requests push expected transactions,
// a monitor process pops and compares them as the DUT strobes memory and pulses completions.
module tb_acc_mem_arbiter;

   localparam int NUM_ACC = 2;
   localparam int AW      = 16;
   localparam int RDW     = 512;
   localparam int WDW     = 32;
   localparam int RD_LAT  = 2;
   localparam int BUDGET  = 200;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b0;
   logic [NUM_ACC-1:0]      acc_rd_en = '0;
   logic [NUM_ACC*AW-1:0]   acc_rd_addr = '0;
   logic [NUM_ACC-1:0]      acc_wr_en = '0;
   logic [NUM_ACC*AW-1:0]   acc_wr_addr = '0;
   logic [NUM_ACC*WDW-1:0]  acc_wr_data = '0;
   logic [RDW-1:0]          acc_rd_data;
   logic [NUM_ACC-1:0]      acc_rd_data_valid;
   logic [NUM_ACC-1:0]      acc_wr_done;
   logic                    mem_rd_en;
   logic                    mem_wr_en;
   logic [AW-1:0]           mem_addr;
   logic [WDW-1:0]          mem_wr_data;
   logic [RDW-1:0]          mem_rd_data;
   logic                    busy;

   acc_mem_arbiter #(
      .NUM_ACC(NUM_ACC), .ADDR_SIZE(AW), .RD_DATA_SIZE(RDW),
      .WR_DATA_SIZE(WDW), .RD_LATENCY(RD_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .acc_rd_en(acc_rd_en), .acc_rd_addr(acc_rd_addr),
      .acc_wr_en(acc_wr_en), .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data),
      .acc_rd_data(acc_rd_data), .acc_rd_data_valid(acc_rd_data_valid),
      .acc_wr_done(acc_wr_done),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory returns data RD_LAT cycles after the read strobe, zero otherwise.
   function automatic logic [RDW-1:0] mem_fn(logic [AW-1:0] a);
      return (a == 16'h1000) ? 512'hABCD : {32{a}};
   endfunction

   logic [RDW-1:0] rd_pipe [RD_LAT];
   always @(posedge clk) begin
      rd_pipe[0] <= mem_rd_en ? mem_fn(mem_addr) : '0;
      for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rd_data = rd_pipe[RD_LAT-1];

   typedef struct {
      bit             is_wr;
      int             id;
      logic [AW-1:0]  addr;
      logic [WDW-1:0] wdata;
      logic [RDW-1:0] rdata;
      int             mem_cyc;
      int             rsp_cyc;
   } exp_t;

   typedef struct {
      bit             wr;
      bit             rd;
      logic [AW-1:0]  waddr;
      logic [WDW-1:0] wdata;
      logic [AW-1:0]  raddr;
   } op_t;

   exp_t exp_q[$];
   op_t  pend0[$];
   op_t  pend1[$];
   int   n_cmp  = 0;
   int   n_fail = 0;
   bit   done   = 1'b0;

   task automatic check(string name, logic [RDW-1:0] act, logic [RDW-1:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic note_fail(string name, string detail);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: %s (cycle %0d)", name, detail, cyc);
   endtask

   function automatic void exp_wr(int id, logic [AW-1:0] a, logic [WDW-1:0] d, int mc, int rc);
      exp_t e;
      e.is_wr = 1'b1; e.id = id; e.addr = a; e.wdata = d; e.rdata = '0;
      e.mem_cyc = mc; e.rsp_cyc = rc;
      exp_q.push_back(e);
   endfunction

   function automatic void exp_rd(int id, logic [AW-1:0] a, logic [RDW-1:0] r, int mc, int rc);
      exp_t e;
      e.is_wr = 1'b0; e.id = id; e.addr = a; e.wdata = '0; e.rdata = r;
      e.mem_cyc = mc; e.rsp_cyc = rc;
      exp_q.push_back(e);
   endfunction

   function automatic void req_op(int id, bit wr, bit rd, logic [AW-1:0] wa,
                                  logic [WDW-1:0] wd, logic [AW-1:0] ra);
      op_t o;
      o.wr = wr; o.rd = rd; o.waddr = wa; o.wdata = wd; o.raddr = ra;
      if (id == 0) pend0.push_back(o);
      else         pend1.push_back(o);
   endfunction

   task automatic launch(int i, op_t o);
      acc_wr_en[i]               = o.wr;
      acc_rd_en[i]               = o.rd;
      acc_wr_addr[i*AW +: AW]    = o.waddr;
      acc_wr_data[i*WDW +: WDW]  = o.wdata;
      acc_rd_addr[i*AW +: AW]    = o.raddr;
   endtask

   // One cycle of requester behaviour: drop a request on its pulse, then issue the next queued op.
   task automatic step();
      @(negedge clk);
      for (int i = 0; i < NUM_ACC; i++) begin
         if (acc_wr_done[i])       acc_wr_en[i] = 1'b0;
         if (acc_rd_data_valid[i]) acc_rd_en[i] = 1'b0;
      end
      if (!acc_wr_en[0] && !acc_rd_en[0] && pend0.size() > 0) launch(0, pend0.pop_front());
      if (!acc_wr_en[1] && !acc_rd_en[1] && pend1.size() > 0) launch(1, pend1.pop_front());
   endtask

   task automatic wait_idle(string name);
      int n = 0;
      while (!(exp_q.size() == 0 && pend0.size() == 0 && pend1.size() == 0 &&
               acc_wr_en == '0 && acc_rd_en == '0 && !busy) && n < BUDGET) begin
         step();
         n++;
      end
      check({name, " completes within budget"}, RDW'(n < BUDGET), RDW'(1));
   endtask

   task automatic monitor();
      exp_t e;
      logic [NUM_ACC-1:0] oh;
      while (!done) begin
         @(negedge clk);
         if (mem_wr_en || mem_rd_en) begin
            if (exp_q.size() == 0) begin
               note_fail("mem strobe", "strobe seen with no transaction expected");
            end else begin
               e = exp_q[0];
               check("strobe kind", RDW'({mem_wr_en, mem_rd_en}), RDW'(e.is_wr ? 2'b10 : 2'b01));
               check("mem_addr", RDW'(mem_addr), RDW'(e.addr));
               check("mem_wr_data", RDW'(mem_wr_data), RDW'(e.is_wr ? e.wdata : '0));
               if (e.mem_cyc >= 0) check("strobe cycle", RDW'(cyc), RDW'(e.mem_cyc));
            end
         end else begin
            check("idle bus zero", RDW'({mem_addr, mem_wr_data}), '0);
         end
         if (acc_wr_done != '0 || acc_rd_data_valid != '0) begin
            if (exp_q.size() == 0) begin
               note_fail("completion pulse", "pulse seen with no transaction outstanding");
            end else begin
               e  = exp_q.pop_front();
               oh = NUM_ACC'(1) << e.id;
               check("pulse owner", RDW'({acc_wr_done, acc_rd_data_valid}),
                     RDW'(e.is_wr ? {oh, {NUM_ACC{1'b0}}} : {{NUM_ACC{1'b0}}, oh}));
               if (!e.is_wr) check("acc_rd_data", acc_rd_data, e.rdata);
               if (e.rsp_cyc >= 0) check("pulse cycle", RDW'(cyc), RDW'(e.rsp_cyc));
            end
         end
      end
   endtask

   task automatic stimulus();
      int c;
      // Reset state
      repeat (3) step();
      check("reset strobes/pulses/busy",
            RDW'({busy, mem_rd_en, mem_wr_en, acc_wr_done, acc_rd_data_valid, mem_addr, mem_wr_data}), '0);
      check("reset acc_rd_data", acc_rd_data, '0);
      rst_n = 1'b1;
      step();

      // Single write from requester 0: strobe 1 cycle later, done 2 cycles later
      req_op(0, 1'b1, 1'b0, 16'h5000, 32'h5, 16'h0);
      step();
      c = cyc;
      exp_wr(0, 16'h5000, 32'h5, c + 1, c + 2);
      step();
      check("busy during write", RDW'(busy), RDW'(1));
      step();
      step();
      check("busy low after write", RDW'(busy), RDW'(0));
      wait_idle("single write");

      // Single read from requester 1: valid pulse RD_LAT+2 cycles after request
      req_op(1, 1'b0, 1'b1, 16'h0, 32'h0, 16'h1000);
      step();
      c = cyc;
      exp_rd(1, 16'h1000, 512'hABCD, c + 1, c + RD_LAT + 2);
      wait_idle("single read");

      // Continuous writes from both requesters alternate 0,1,0,1
      exp_wr(0, 16'h0100, 32'h11, -1, -1);
      exp_wr(1, 16'h0201, 32'h21, -1, -1);
      exp_wr(0, 16'h0102, 32'h12, -1, -1);
      exp_wr(1, 16'h0203, 32'h23, -1, -1);
      req_op(0, 1'b1, 1'b0, 16'h0100, 32'h11, 16'h0);
      req_op(0, 1'b1, 1'b0, 16'h0102, 32'h12, 16'h0);
      req_op(1, 1'b1, 1'b0, 16'h0201, 32'h21, 16'h0);
      req_op(1, 1'b1, 1'b0, 16'h0203, 32'h23, 16'h0);
      wait_idle("round robin");
      check("acc_rd_data held across writes", acc_rd_data, 512'hABCD);

      // Same requester read+write: write first, read on a later grant
      exp_wr(0, 16'h2004, 32'h77, -1, -1);
      exp_rd(0, 16'h2000, {32{16'h2000}}, -1, -1);
      req_op(0, 1'b1, 1'b1, 16'h2004, 32'h77, 16'h2000);
      wait_idle("read+write same requester");

      // Back-to-back: requester 0 re-requests at once, waiting requester 1 goes next
      exp_wr(1, 16'h3100, 32'h31, -1, -1);
      req_op(1, 1'b1, 1'b0, 16'h3100, 32'h31, 16'h0);
      wait_idle("pointer setup");
      exp_wr(0, 16'h3000, 32'h30, -1, -1);
      exp_wr(1, 16'h3101, 32'h32, -1, -1);
      exp_wr(0, 16'h3002, 32'h33, -1, -1);
      req_op(0, 1'b1, 1'b0, 16'h3000, 32'h30, 16'h0);
      req_op(0, 1'b1, 1'b0, 16'h3002, 32'h33, 16'h0);
      req_op(1, 1'b1, 1'b0, 16'h3101, 32'h32, 16'h0);
      wait_idle("back-to-back");

      // Reset during RD_WAIT aborts the read with no pulse
      req_op(0, 1'b0, 1'b1, 16'h0, 32'h0, 16'h4000);
      step();
      c = cyc;
      exp_rd(0, 16'h4000, {32{16'h4000}}, c + 1, -1);
      step();
      step();
      check("busy in RD_WAIT", RDW'(busy), RDW'(1));
      rst_n = 1'b0;
      step();
      check("mid-read reset outputs",
            RDW'({busy, mem_rd_en, mem_wr_en, acc_wr_done, acc_rd_data_valid, mem_addr, mem_wr_data}), '0);
      check("mid-read reset acc_rd_data", acc_rd_data, '0);
      exp_q.delete();
      acc_rd_en = '0;
      acc_wr_en = '0;
      rst_n = 1'b1;

      // Fresh traffic after reset: pointer back at 0, so requester 0 wins first
      exp_wr(0, 16'h5100, 32'h51, -1, -1);
      exp_wr(1, 16'h5201, 32'h52, -1, -1);
      exp_rd(1, 16'h1000, 512'hABCD, -1, -1);
      req_op(0, 1'b1, 1'b0, 16'h5100, 32'h51, 16'h0);
      req_op(1, 1'b1, 1'b0, 16'h5201, 32'h52, 16'h0);
      req_op(1, 1'b0, 1'b1, 16'h0, 32'h0, 16'h1000);
      wait_idle("after reset");

      repeat (4) step();
      done = 1'b1;
   endtask

   initial begin
      fork
         monitor();
         stimulus();
      join
      check("scoreboard drained", RDW'(exp_q.size()), '0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
